data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/cache_line_array.sv | 40 ++++
 rtl/data_cache.sv | 137 +++++++++++++
 tb/tb_data_cache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data cache.
//  - Geometry constants (8-bit byte address, 8 lines of 4 bytes).
//  - FSM state enum and the per-line storage record.
//  - Address field slicing helpers: {tag, index, offset}.
package cache_pkg;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 8;
   localparam int N_BLOCKS    = 8;
   localparam int BLOCK_BYTES = 4;
   localparam int IDX_W       = 3;
   localparam int OFF_W       = 2;
   localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
   localparam int BLOCK_W     = BLOCK_BYTES * DATA_W;
   localparam int MADDR_W     = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      FETCH      = 2'd2
   } state_t;

   typedef struct packed {
      logic               valid;
      logic               dirty;
      logic [TAG_W-1:0]   tag;
      logic [BLOCK_W-1:0] data;
   } line_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[OFF_W-1:0];
   endfunction

   // Block (line) address as seen by main memory: {tag, index}.
   function automatic logic [MADDR_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:OFF_W];
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: N_BLOCKS x {valid, dirty, tag, data}.
// Ports:
//  CLK, RESET    clock, synchronous active-high clear of every line
//  idx           line selected for both the read port and the write port
//  rd_line       asynchronous read of line idx
//  byte_we       store one byte (byte_off/byte_data) into line idx, mark dirty
//  refill_we     replace line idx with a clean, valid line (refill_tag/data)
module cache_line_array
   import cache_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic [IDX_W-1:0]   idx,
   output line_t              rd_line,
   input  logic               byte_we,
   input  logic [OFF_W-1:0]   byte_off,
   input  logic [DATA_W-1:0]  byte_data,
   input  logic               refill_we,
   input  logic [TAG_W-1:0]   refill_tag,
   input  logic [BLOCK_W-1:0] refill_data
);

   line_t lines [N_BLOCKS];

   assign rd_line = lines[idx];

   // Reset wins over any write in the same cycle so an abandoned refill
   // never lands in a freshly cleared array.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < N_BLOCKS; i++) lines[i] <= '0;
      end else if (refill_we) begin
         lines[idx] <= '{valid: 1'b1, dirty: 1'b0, tag: refill_tag, data: refill_data};
      end else if (byte_we) begin
         lines[idx].data[DATA_W*int'(byte_off) +: DATA_W] <= byte_data;
         lines[idx].dirty <= 1'b1;
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits complete with no stall; a miss stalls the CPU (BUSYWAIT) while the
// victim line is written back (if dirty) and the requested block is fetched.
// Ports:
//  CLK, RESET                 clock, synchronous active-high reset
//  READ, WRITE                CPU request (held until BUSYWAIT low); both = write
//  ADDRESS, WRITEDATA         CPU byte address and store data
//  READDATA, BUSYWAIT         CPU load data and stall
//  MEM_READ, MEM_WRITE        block fetch / write-back request
//  MEM_ADDRESS                block address {tag, index}
//  MEM_WRITEDATA              victim block, byte0 in [7:0]
//  MEM_READDATA, MEM_BUSYWAIT fetched block and memory stall
module data_cache
   import cache_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               READ,
   input  logic               WRITE,
   input  logic [ADDR_W-1:0]  ADDRESS,
   input  logic [DATA_W-1:0]  WRITEDATA,
   output logic [DATA_W-1:0]  READDATA,
   output logic               BUSYWAIT,
   output logic               MEM_READ,
   output logic               MEM_WRITE,
   output logic [MADDR_W-1:0] MEM_ADDRESS,
   output logic [BLOCK_W-1:0] MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0] MEM_READDATA,
   input  logic               MEM_BUSYWAIT
);

   state_t            state;
   logic              mem_read_q;
   logic              mem_write_q;

   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off;
   line_t             line;
   logic              req;
   logic              hit;
   logic              idle;
   logic              byte_we;
   logic              refill_we;
   logic [DATA_W-1:0] line_byte;

   assign tag  = addr_tag(ADDRESS);
   assign idx  = addr_idx(ADDRESS);
   assign off  = addr_off(ADDRESS);
   assign req  = READ | WRITE;
   assign idle = (state == IDLE);
   assign hit  = line.valid && (line.tag == tag);

   // A store hit commits on the next edge; a finished fetch replaces the line.
   assign byte_we   = idle && WRITE && hit;
   assign refill_we = (state == FETCH) && !MEM_BUSYWAIT;

   cache_line_array u_lines (
      .CLK         (CLK),
      .RESET       (RESET),
      .idx         (idx),
      .rd_line     (line),
      .byte_we     (byte_we),
      .byte_off    (off),
      .byte_data   (WRITEDATA),
      .refill_we   (refill_we),
      .refill_tag  (tag),
      .refill_data (MEM_READDATA)
   );

   assign line_byte = line.data[DATA_W*int'(off) +: DATA_W];

   // A simultaneous READ+WRITE is a store, so it returns no load data.
   assign READDATA = (idle && READ && !WRITE && hit) ? line_byte : '0;
   assign BUSYWAIT = idle ? (req && !hit) : 1'b1;

   // Memory request strobes are registered alongside the state so they
   // change only on clock edges and drop the cycle after a reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req && !hit) begin
                  if (line.valid && line.dirty) begin
                     state       <= WRITE_BACK;
                     mem_write_q <= 1'b1;
                  end else begin
                     state       <= FETCH;
                     mem_read_q  <= 1'b1;
                  end
               end
            end
            WRITE_BACK: begin
               if (!MEM_BUSYWAIT) begin
                  state       <= FETCH;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b1;
               end
            end
            FETCH: begin
               if (!MEM_BUSYWAIT) begin
                  state      <= IDLE;
                  mem_read_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign MEM_READ  = mem_read_q;
   assign MEM_WRITE = mem_write_q;

   // During write-back the victim's stored tag names the block; during fetch
   // the CPU address does. Both buses idle at zero otherwise.
   always_comb begin
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      case (state)
         WRITE_BACK: begin
            MEM_ADDRESS   = {line.tag, idx};
            MEM_WRITEDATA = line.data;
         end
         FETCH: MEM_ADDRESS = addr_blk(ADDRESS);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        READ, WRITE;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ, MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA, MEM_READDATA;
   logic        MEM_BUSYWAIT;

   always #5 CLK = ~CLK;

   data_cache dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   // ---------------- main memory model ----------------
   logic [31:0] mem [64];
   int          mem_lat = 0;
   int          mem_cnt = 0;
   logic        mem_done = 1'b0;

   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && !mem_done;
   assign MEM_READDATA = mem[MEM_ADDRESS];

   // Busy for mem_lat rising edges after a request appears, done on the next.
   always @(negedge CLK) begin
      if (mem_done) begin
         mem_done = 1'b0;
         mem_cnt  = 0;
      end
      if (MEM_READ | MEM_WRITE) begin
         if (mem_cnt >= mem_lat) begin
            mem_done = 1'b1;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   // ---------------- reference model ----------------
   // The cache must be transparent: every load returns the last value stored
   // to that byte address (golden). Line residency is tracked only to predict
   // hit/miss and write-back traffic.
   logic [7:0] golden [256];
   logic       ref_valid [8];
   logic       ref_dirty [8];
   logic [2:0] ref_tag   [8];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int a = 0; a < 256; a++) golden[a] = mem[a >> 2][8*(a % 4) +: 8];
      for (int i = 0; i < 8; i++) begin
         ref_valid[i] = 1'b0;
         ref_dirty[i] = 1'b0;
         ref_tag[i]   = 3'd0;
      end
   endtask

   task automatic model_update(input logic wr, input logic [7:0] a, input logic [7:0] wd);
      logic [2:0] ix;
      ix = a[4:2];
      if (!(ref_valid[ix] && ref_tag[ix] == a[7:5])) begin
         ref_valid[ix] = 1'b1;
         ref_tag[ix]   = a[7:5];
         ref_dirty[ix] = 1'b0;
      end
      if (wr) begin
         golden[a]     = wd;
         ref_dirty[ix] = 1'b1;
      end
   endtask

   // Called just after a rising edge; returns just after the edge on which
   // the access completes.
   task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] wd, input int lat,
                         input logic [7:0] exp_rd, input int exp_stall,
                         input logic exp_wb, input logic [5:0] exp_wba,
                         input logic [31:0] exp_wbd, input logic [5:0] exp_fa,
                         input string nm);
      int stall, wbc, fc, ovl;
      logic [5:0]  wba, fa;
      logic [31:0] wbd;
      stall = 0; wbc = 0; fc = 0; ovl = 0;
      wba = '0; fa = '0; wbd = '0;
      mem_lat   = lat;
      READ      = rd;
      WRITE     = wr;
      ADDRESS   = a;
      WRITEDATA = wd;
      #1;
      while (BUSYWAIT && stall < 200) begin
         stall++;
         if (MEM_WRITE) begin
            if (wbc == 0) begin wba = MEM_ADDRESS; wbd = MEM_WRITEDATA; end
            wbc++;
         end
         if (MEM_READ) begin
            if (fc == 0) fa = MEM_ADDRESS;
            fc++;
         end
         if (MEM_READ && MEM_WRITE) ovl++;
         tick();
      end
      chk({nm, " stall"}, stall, exp_stall);
      chk({nm, " readdata"}, {24'd0, READDATA}, {24'd0, exp_rd});
      chk({nm, " wb_cycles"}, wbc, exp_wb ? lat + 1 : 0);
      chk({nm, " fetch_cycles"}, fc, (exp_stall != 0) ? lat + 1 : 0);
      chk({nm, " overlap"}, ovl, 0);
      if (exp_wb) begin
         chk({nm, " wb_addr"}, {26'd0, wba}, {26'd0, exp_wba});
         chk({nm, " wb_data"}, wbd, exp_wbd);
      end
      if (exp_stall != 0) chk({nm, " fetch_addr"}, {26'd0, fa}, {26'd0, exp_fa});
      tick();
      READ  = 1'b0;
      WRITE = 1'b0;
   endtask

   typedef struct {
      logic        rd, wr;
      logic [7:0]  a, wd;
      int          lat;
      logic [7:0]  exp_rd;
      int          exp_stall;
      logic        exp_wb;
      logic [5:0]  exp_wba;
      logic [31:0] exp_wbd;
      logic [5:0]  exp_fa;
   } vec_t;

   vec_t tbl [7];

   initial begin
      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[6'h01] = 32'hDDCCBBAA;
      mem[6'h09] = 32'h44332211;

      //        rd    wr    addr   wd     lat rdata  stall wb    wba    wbd            fa
      tbl[0] = '{1'b1, 1'b0, 8'h05, 8'h00, 1, 8'hBB, 3,    1'b0, 6'h00, 32'h0,         6'h01};
      tbl[1] = '{1'b0, 1'b1, 8'h05, 8'h7E, 0, 8'h00, 0,    1'b0, 6'h00, 32'h0,         6'h00};
      tbl[2] = '{1'b1, 1'b0, 8'h05, 8'h00, 0, 8'h7E, 0,    1'b0, 6'h00, 32'h0,         6'h00};
      tbl[3] = '{1'b1, 1'b0, 8'h25, 8'h00, 2, 8'h22, 7,    1'b1, 6'h01, 32'hDDCC7EAA, 6'h09};
      tbl[4] = '{1'b1, 1'b1, 8'h25, 8'h5A, 0, 8'h00, 0,    1'b0, 6'h00, 32'h0,         6'h00};
      tbl[5] = '{1'b1, 1'b0, 8'h25, 8'h00, 0, 8'h5A, 0,    1'b0, 6'h00, 32'h0,         6'h00};
      tbl[6] = '{1'b1, 1'b0, 8'h05, 8'h00, 5, 8'h7E, 13,   1'b1, 6'h09, 32'h44335A11, 6'h01};

      // Reset state
      tick(); tick();
      chk("rst readdata", {24'd0, READDATA}, 32'd0);
      chk("rst busywait", {31'd0, BUSYWAIT}, 32'd0);
      chk("rst mem_read", {31'd0, MEM_READ}, 32'd0);
      chk("rst mem_write", {31'd0, MEM_WRITE}, 32'd0);
      chk("rst mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
      chk("rst mem_writedata", MEM_WRITEDATA, 32'd0);
      RESET = 1'b0;
      model_reset();
      tick();

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].lat, tbl[i].exp_rd,
                tbl[i].exp_stall, tbl[i].exp_wb, tbl[i].exp_wba, tbl[i].exp_wbd,
                tbl[i].exp_fa, $sformatf("vec%0d", i));
         model_update(tbl[i].wr, tbl[i].a, tbl[i].wd);
      end
      chk("mem01 after wb", mem[6'h01], 32'hDDCC7EAA);
      chk("mem09 after wb", mem[6'h09], 32'h44335A11);

      // Reset in the middle of a fetch abandons it
      mem_lat = 5;
      READ = 1'b1; ADDRESS = 8'h45;
      tick();
      chk("midrst fetch mem_read", {31'd0, MEM_READ}, 32'd1);
      chk("midrst fetch addr", {26'd0, MEM_ADDRESS}, 32'h11);
      tick();
      RESET = 1'b1; READ = 1'b0;
      tick();
      chk("midrst mem_read", {31'd0, MEM_READ}, 32'd0);
      chk("midrst busywait", {31'd0, BUSYWAIT}, 32'd0);
      chk("midrst mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
      RESET = 1'b0;
      model_reset();
      tick();
      access(1'b1, 1'b0, 8'h05, 8'h00, 1, 8'h7E, 3, 1'b0, 6'h00, 32'h0, 6'h01, "postrst");
      model_update(1'b0, 8'h05, 8'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 200; n++) begin
         logic       rd, wr, hit, wb;
         logic [7:0] a, wd, erd;
         logic [2:0] ix;
         logic [5:0] vb;
         logic [31:0] vd;
         int         lat, kind, st;
         kind = int'($urandom_range(0, 2));
         rd   = (kind != 1);
         wr   = (kind != 0);
         a    = 8'($urandom);
         wd   = 8'($urandom);
         lat  = int'($urandom_range(0, 3));
         ix   = a[4:2];
         hit  = ref_valid[ix] && ref_tag[ix] == a[7:5];
         wb   = !hit && ref_valid[ix] && ref_dirty[ix];
         vb   = {ref_tag[ix], ix};
         vd   = {golden[{vb, 2'd3}], golden[{vb, 2'd2}], golden[{vb, 2'd1}], golden[{vb, 2'd0}]};
         st   = hit ? 0 : (2 + lat + (wb ? lat + 1 : 0));
         erd  = (rd && !wr) ? golden[a] : 8'h00;
         access(rd, wr, a, wd, lat, erd, st, wb, vb, vd, a[7:2], $sformatf("rnd%0d", n));
         model_update(wr, a, wd);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
